bullet_track: RTL and testbench

- Upstream producer of the 119-bit bullet bitmap consumed by the invader/bullet collision checkers.
- Turns the player's fire button into bullets and advances all bullets one position per step tick.
- Removes bullets that leave the field or that a collision checker reports as hit.
- Bit k of bulletData means a bullet at screen x = k+43.

---
 rtl/bullet_track_if.sv | 24 ++
 rtl/bullet_track.sv | 188 ++++++++++++++++++
 tb/tb_bullet_track.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_track_if.sv
// bullet_track_if: groups the fire/hit inputs and the bitmap/status outputs
// of bullet_track. The slave modport is the tracker; master is whoever
// drives fire/hit and consumes the bitmap.
interface bullet_track_if #(
  parameter int TRACK_W = 119
);
  logic               fire;
  logic               hitValid;
  logic [6:0]         hitIndex;
  logic [TRACK_W-1:0] bulletData;
  logic [3:0]         inFlight;
  logic               stepTick;
  logic               fireDropped;

  modport master (
    output fire, hitValid, hitIndex,
    input  bulletData, inFlight, stepTick, fireDropped
  );

  modport slave (
    input  fire, hitValid, hitIndex,
    output bulletData, inFlight, stepTick, fireDropped
  );
endinterface

// File: rtl/bullet_track.sv
// bullet_track: turns fire presses into bullets and advances the bullet
// bitmap one position per step tick. Bit k of bulletData is a bullet at
// screen x = k+43. Bullets fall off the top bit or are cleared by a hit.
// Optional feature macro: BULLET_AUTOFIRE_EN (hold fire to repeat shots;
// a refused shot re-arms instead of waiting for release).
module bullet_track #(
  parameter int TRACK_W        = 119,
  parameter int STEP_DIV       = 2500000,
  parameter int COOLDOWN_STEPS = 8,
  parameter int MAX_IN_FLIGHT  = 4
) (
  input  logic          clock,
  input  logic          resetn,
  bullet_track_if.slave bus
);

`ifdef BULLET_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int COOL_W = $clog2(COOLDOWN_STEPS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_STEPS);

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    PENDING      = 2'd1,
    COOLDOWN     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Fire synchronizer and edge detect
  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic fire_rise;

  // Step divider
  logic [DIV_W-1:0] div_reg;
  logic             step_reg;
  logic             tick;

  // Bitmap and occupancy
  logic [TRACK_W-1:0] bullets_reg;
  logic [TRACK_W-1:0] bullets_next;
  logic [3:0]         count_reg;
  logic [3:0]         count_next;
  logic [TRACK_W-1:0] clr_mask;
  logic [TRACK_W-1:0] masked;
  logic               clear_hit;
  logic               leaving;
  logic [4:0]         survivors;
  logic               accept;
  logic               inject;

  // Fire FSM
  state_t             state_reg;
  logic [COOL_W-1:0]  cool_reg;
  logic               cool_last;
  logic               dropped_reg;

  // Two-flop synchronizer on the raw button, plus a history flop for edges
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= bus.fire;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign fire_rise = sync2_reg & ~prev_reg;

  // tick is the cycle the divider sits at its last count; the bitmap moves
  // on the edge that ends this cycle, the same edge that raises stepTick.
  assign tick = (div_reg == DIV_LAST);

  // Free-running step divider with a registered one-cycle tick pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_reg  <= '0;
      step_reg <= 1'b0;
    end else begin
      step_reg <= tick;
      if (tick) begin
        div_reg <= '0;
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  // One-hot clear mask; an index beyond the bitmap matches no bit, so
  // out-of-range hits fall through without effect.
  generate
    for (genvar gi = 0; gi < TRACK_W; gi++) begin : g_clr
      assign clr_mask[gi] = bus.hitValid && (bus.hitIndex == 7'(gi));
    end
  endgenerate

  assign masked    = bullets_reg & ~clr_mask;
  assign clear_hit = |(bullets_reg & clr_mask);
  // A bullet cleared at the top bit this cycle is not also counted as leaving
  assign leaving   = tick & masked[TRACK_W-1];

  // Bullets still present after this cycle's clear and exit. These are
  // distinct bits, so the subtraction cannot go below zero.
  assign survivors = {1'b0, count_reg} - 5'(clear_hit) - 5'(leaving);
  assign accept    = (survivors < 5'(MAX_IN_FLIGHT));
  assign inject    = tick && (state_reg == PENDING) && accept;

  assign bullets_next = tick ? {masked[TRACK_W-2:0], inject} : masked;
  assign count_next   = count_reg + 4'(inject) - 4'(leaving) - 4'(clear_hit);

  // Bitmap and its incrementally maintained population count
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bullets_reg <= '0;
      count_reg   <= '0;
    end else begin
      bullets_reg <= bullets_next;
      count_reg   <= count_next;
    end
  end

  assign cool_last = (cool_reg <= COOL_W'(1));

  // Fire FSM: arm on a press, shoot on the next step, then cool down
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ARMED;
      cool_reg    <= '0;
      dropped_reg <= 1'b0;
    end else begin
      dropped_reg <= 1'b0;
      case (state_reg)
        ARMED: begin
          if (fire_rise) begin
            state_reg <= PENDING;
          end
        end
        PENDING: begin
          if (tick) begin
            if (accept) begin
              state_reg <= COOLDOWN;
              cool_reg  <= COOL_LOAD;
            end else begin
              dropped_reg <= 1'b1;
              state_reg   <= AUTOFIRE ? ARMED : WAIT_RELEASE;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cool_last) begin
              cool_reg <= '0;
              if (sync2_reg) begin
                state_reg <= AUTOFIRE ? PENDING : WAIT_RELEASE;
              end else begin
                state_reg <= ARMED;
              end
            end else begin
              cool_reg <= cool_reg - COOL_W'(1);
            end
          end
        end
        WAIT_RELEASE: begin
          if (!sync2_reg) begin
            state_reg <= ARMED;
          end
        end
        default: state_reg <= ARMED;
      endcase
    end
  end

  assign bus.bulletData  = bullets_reg;
  assign bus.inFlight    = count_reg;
  assign bus.stepTick    = step_reg;
  assign bus.fireDropped = dropped_reg;

endmodule

// File: tb/tb_bullet_track.sv
// tb_bullet_track: directed scenarios for bullet_track with STEP_DIV=4,
// COOLDOWN_STEPS=2, MAX_IN_FLIGHT=2. Inputs change and outputs are sampled
// on the falling clock edge. Tick T1 is the step that injects the first shot.
module tb_bullet_track;
  localparam int TW = 119;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  bullet_track_if #(.TRACK_W(TW)) bus ();

  bullet_track #(
    .TRACK_W       (TW),
    .STEP_DIV      (4),
    .COOLDOWN_STEPS(2),
    .MAX_IN_FLIGHT (2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [127:0] bit_at(input int k);
    logic [127:0] one;
    one = 128'd1;
    return one << k;
  endfunction

  // Advance to the falling edge inside the next stepTick cycle (bounded)
  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      if (bus.stepTick) seen = 1'b1;
    end
    check_val({tag, "_tick"}, 128'(seen), 128'd1);
  endtask

  // Reset, check reset outputs, then release with fire optionally held
  task automatic do_reset(input bit fire_at_release);
    @(negedge clock);
    resetn       = 1'b0;
    bus.fire     = 1'b0;
    bus.hitValid = 1'b0;
    bus.hitIndex = 7'd0;
    @(negedge clock);
    check_val("rst_data",    bus.bulletData,         128'd0);
    check_val("rst_flight",  128'(bus.inFlight),     128'd0);
    check_val("rst_step",    128'(bus.stepTick),     128'd0);
    check_val("rst_dropped", 128'(bus.fireDropped),  128'd0);
    @(negedge clock);
    bus.fire = fire_at_release;
    resetn   = 1'b1;
  endtask

  // Two-cycle button press starting in a stepTick cycle: injects next tick
  task automatic press();
    bus.fire = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.fire = 1'b0;
  endtask

  // Fresh reset with one bullet injected at tick T1 (bit 0); fire released
  task automatic first_shot(input string tag);
    do_reset(1'b1);
    wait_tick(tag);
    bus.fire = 1'b0;
  endtask

  initial begin
    bus.fire     = 1'b0;
    bus.hitValid = 1'b0;
    bus.hitIndex = 7'd0;

    // Single shot travels the whole field and drops off the top
    do_reset(1'b1);
    wait_tick("a_first");
    check_val("a_first_data",   bus.bulletData,     bit_at(0));
    check_val("a_first_flight", 128'(bus.inFlight), 128'd1);
    @(negedge clock);
    check_val("a_step_pulse",   128'(bus.stepTick), 128'd0);
    bus.fire = 1'b0;
    for (int i = 0; i < 118; i++) wait_tick("a_fly");
    check_val("a_top_data",     bus.bulletData,     bit_at(118));
    check_val("a_top_flight",   128'(bus.inFlight), 128'd1);
    wait_tick("a_exit");
    check_val("a_exit_data",    bus.bulletData,     128'd0);
    check_val("a_exit_flight",  128'(bus.inFlight), 128'd0);

    // Hit removal on non-step cycles, including ignored indices
    first_shot("b_shot");
    for (int i = 0; i < 5; i++) wait_tick("b_fly");
    check_val("b_at5", bus.bulletData, bit_at(5));
    bus.hitValid = 1'b1;
    bus.hitIndex = 7'd120;
    @(negedge clock);
    check_val("b_oob_data",    bus.bulletData,     bit_at(5));
    check_val("b_oob_flight",  128'(bus.inFlight), 128'd1);
    bus.hitIndex = 7'd6;
    @(negedge clock);
    check_val("b_empty_data",   bus.bulletData,     bit_at(5));
    check_val("b_empty_flight", 128'(bus.inFlight), 128'd1);
    bus.hitIndex = 7'd5;
    @(negedge clock);
    bus.hitValid = 1'b0;
    check_val("b_hit_data",    bus.bulletData,     128'd0);
    check_val("b_hit_flight",  128'(bus.inFlight), 128'd0);

    // Hit on the step cycle: clear applies before the shift
    first_shot("c_shot");
    for (int i = 0; i < 3; i++) wait_tick("c_cool");
    press();
    wait_tick("c_second");
    check_val("c_two_data",   bus.bulletData,     bit_at(4) | bit_at(0));
    check_val("c_two_flight", 128'(bus.inFlight), 128'd2);
    for (int i = 0; i < 5; i++) wait_tick("c_fly");
    check_val("c_pre_data", bus.bulletData, bit_at(9) | bit_at(5));
    repeat (3) @(negedge clock);
    bus.hitValid = 1'b1;
    bus.hitIndex = 7'd9;
    @(negedge clock);
    bus.hitValid = 1'b0;
    check_val("c_step_seen",   128'(bus.stepTick), 128'd1);
    check_val("c_step_data",   bus.bulletData,     bit_at(6));
    check_val("c_step_flight", 128'(bus.inFlight), 128'd1);

    // Capacity: refused with two in flight, accepted when one exits
    first_shot("d_shot");
    for (int i = 0; i < 3; i++) wait_tick("d_cool");
    press();
    wait_tick("d_second");
    check_val("d_two_flight", 128'(bus.inFlight), 128'd2);
    wait_tick("d_t5");
    wait_tick("d_t6");
    press();
    wait_tick("d_t7");
    check_val("d_drop_pulse",  128'(bus.fireDropped), 128'd1);
    check_val("d_drop_data",   bus.bulletData,        bit_at(7) | bit_at(3));
    check_val("d_drop_flight", 128'(bus.inFlight),    128'd2);
    @(negedge clock);
    check_val("d_drop_once",   128'(bus.fireDropped), 128'd0);
    for (int i = 0; i < 111; i++) wait_tick("d_fly");
    check_val("d_t118_data", bus.bulletData, bit_at(118) | bit_at(114));
    press();
    wait_tick("d_t119");
    check_val("d_exit_data",    bus.bulletData,        bit_at(115) | bit_at(0));
    check_val("d_exit_flight",  128'(bus.inFlight),    128'd2);
    check_val("d_exit_dropped", 128'(bus.fireDropped), 128'd0);

    // Holding fire for ten ticks, then a fresh press
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) wait_tick("e_hold");
    bus.fire = 1'b0;
`ifdef BULLET_AUTOFIRE_EN
    check_val("e_hold_data",   bus.bulletData,     bit_at(9) | bit_at(6));
    check_val("e_hold_flight", 128'(bus.inFlight), 128'd2);
`else
    check_val("e_hold_data",   bus.bulletData,     bit_at(9));
    check_val("e_hold_flight", 128'(bus.inFlight), 128'd1);
`endif
    wait_tick("e_t11");
    press();
    wait_tick("e_t12");
`ifdef BULLET_AUTOFIRE_EN
    check_val("e_again_data",    bus.bulletData,        bit_at(11) | bit_at(8));
    check_val("e_again_dropped", 128'(bus.fireDropped), 128'd1);
`else
    check_val("e_again_data",    bus.bulletData,        bit_at(11) | bit_at(0));
    check_val("e_again_dropped", 128'(bus.fireDropped), 128'd0);
`endif
    check_val("e_again_flight", 128'(bus.inFlight), 128'd2);

    // Asynchronous reset between clock edges with two bullets in flight
    first_shot("f_shot");
    for (int i = 0; i < 3; i++) wait_tick("f_cool");
    press();
    wait_tick("f_second");
    check_val("f_two_flight", 128'(bus.inFlight), 128'd2);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check_val("f_async_data",   bus.bulletData,     128'd0);
    check_val("f_async_flight", 128'(bus.inFlight), 128'd0);
    check_val("f_async_step",   128'(bus.stepTick), 128'd0);
    @(negedge clock);
    bus.fire = 1'b1;
    resetn   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check_val($sformatf("f_quiet_%0d", i), 128'(bus.stepTick), 128'd0);
    end
    @(negedge clock);
    bus.fire = 1'b0;
    check_val("f_first_step",   128'(bus.stepTick), 128'd1);
    check_val("f_rearm_data",   bus.bulletData,     bit_at(0));
    check_val("f_rearm_flight", 128'(bus.inFlight), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time guard so the bench always ends on its own
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1000000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
